uart_slip_deframer: RTL and testbench

- Sits behind the UART receiver; consumes its one-cycle received-byte strobe and error strobe.
- Decodes SLIP-framed (END/ESC byte-stuffed) packets and verifies a trailing 8-bit two's-complement checksum.
- Delivers the payload plus an end-of-frame status record through a small first-word-fall-through (FWFT) FIFO with valid/ready handshake.
- Host-to-probe counterpart of the framing applied on the transmit path.

---
 rtl/uart_slip_deframer_if.sv | 22 ++
 rtl/uart_slip_deframer.sv | 164 ++++++++++++++++
 tb/tb_uart_slip_deframer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_slip_deframer_if.sv
// Byte-stream and FIFO-output handshake bundle for the SLIP deframer.
// slave is the deframer's view; master is the UART/consumer side.
interface uart_slip_deframer_if;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_error;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_eof;
  logic       out_good;

  modport slave (
    input  in_valid, in_byte, in_error, out_ready,
    output out_valid, out_data, out_eof, out_good
  );

  modport master (
    output in_valid, in_byte, in_error, out_ready,
    input  out_valid, out_data, out_eof, out_good
  );
endinterface

// File: rtl/uart_slip_deframer.sv
// SLIP packet deframer with trailing two's-complement checksum check;
// payload bytes and end-of-frame status records leave through a FWFT FIFO.
module uart_slip_deframer #(
  parameter int MAX_LEN    = 255,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_slip_deframer_if.slave   bus,
  output logic                  overflow,
  output logic                  in_frame
);
  localparam logic [7:0] END_B   = 8'hC0;
  localparam logic [7:0] ESC_B   = 8'hDB;
  localparam logic [7:0] ESC_END = 8'hDC;
  localparam logic [7:0] ESC_ESC = 8'hDD;
  localparam logic [9:0] EOF_BAD = 10'h200;
  localparam int LW = $clog2(MAX_LEN + 3);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {S_HUNT, S_IDLE, S_DATA, S_ESC, S_DISCARD} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    pend_q, pend_d;
  logic          overflow_q, overflow_d;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q;

  logic          push, doDecode, clearCtx, full, pop, write, lost;
  logic [9:0]    pushEntry, head;
  logic [7:0]    decByte;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = bus.out_valid && bus.out_ready;
  assign write = push && (!full || pop);
  assign lost  = push && full && !pop;

  // Each accepted input produces at most one FIFO push; a lost payload push
  // abandons the frame so no later byte can land out of order.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    sum_d      = sum_q;
    pend_d     = pend_q;
    push       = 1'b0;
    pushEntry  = '0;
    doDecode   = 1'b0;
    clearCtx   = 1'b0;
    decByte    = bus.in_byte;
    overflow_d = overflow_q;

    if (bus.in_error) begin
      if (state_q inside {S_IDLE, S_DATA, S_ESC}) begin
        push      = 1'b1;
        pushEntry = EOF_BAD;
        state_d   = S_DISCARD;
        clearCtx  = 1'b1;
      end
    end else if (bus.in_valid) begin
      unique case (state_q)
        S_HUNT:    if (bus.in_byte == END_B) state_d = S_IDLE;
        S_IDLE, S_DATA: begin
          if (bus.in_byte == END_B) begin
            if (state_q == S_DATA) begin
              push      = 1'b1;
              pushEntry = (len_q < LW'(2)) ? EOF_BAD : {1'b1, sum_q == 8'h00, 8'h00};
              state_d   = S_IDLE;
              clearCtx  = 1'b1;
            end
          end else if (bus.in_byte == ESC_B) begin
            state_d = S_ESC;
          end else begin
            doDecode = 1'b1;
          end
        end
        S_ESC: begin
          if (bus.in_byte == ESC_END) begin
            decByte  = END_B;
            doDecode = 1'b1;
          end else if (bus.in_byte == ESC_ESC) begin
            decByte  = ESC_B;
            doDecode = 1'b1;
          end else begin
            push      = 1'b1;
            pushEntry = EOF_BAD;
            state_d   = (bus.in_byte == END_B) ? S_IDLE : S_DISCARD;
            clearCtx  = 1'b1;
          end
        end
        S_DISCARD: if (bus.in_byte == END_B) state_d = S_IDLE;
        default:   state_d = S_HUNT;
      endcase
    end

    if (doDecode) begin
      if (len_q == LW'(MAX_LEN + 1)) begin
        push      = 1'b1;
        pushEntry = EOF_BAD;
        state_d   = S_DISCARD;
        clearCtx  = 1'b1;
      end else begin
        state_d = S_DATA;
        pend_d  = decByte;
        len_d   = len_q + LW'(1);
        sum_d   = sum_q + decByte;
        if (len_q != '0) begin
          push      = 1'b1;
          pushEntry = {2'b00, pend_q};
          if (lost) begin
            state_d  = S_DISCARD;
            clearCtx = 1'b1;
          end
        end
      end
    end

    if (lost) overflow_d = 1'b1;
    if (clearCtx) begin
      len_d  = '0;
      sum_d  = '0;
      pend_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HUNT;
      len_q      <= '0;
      sum_q      <= '0;
      pend_q     <= '0;
      overflow_q <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      pend_q     <= pend_d;
      overflow_q <= overflow_d;
      if (write) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop)   rdPtr_q <= rdPtr_q + PW'(1);
      count_q <= count_q + CW'(write) - CW'(pop);
    end
  end

  // Storage needs no reset: the head is masked whenever the count is zero.
  always_ff @(posedge clk) begin
    if (!rst && write) mem_q[wrPtr_q] <= pushEntry;
  end

  assign head          = mem_q[rdPtr_q];
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = bus.out_valid ? head[7:0] : 8'h00;
  assign bus.out_good  = bus.out_valid ? head[8] : 1'b0;
  assign bus.out_eof   = bus.out_valid ? head[9] : 1'b0;
  assign overflow      = overflow_q;
  assign in_frame      = (state_q == S_DATA) || (state_q == S_ESC);
endmodule

// File: tb/tb_uart_slip_deframer.sv
// Scoreboard bench for uart_slip_deframer: expected FIFO entries are queued
// as frames are sent and compared as the consumer pops them.
module tb_uart_slip_deframer;
  logic clk = 1'b0;
  logic rst;
  logic overflow, in_frame;
  int   errors = 0;
  int   checks = 0;
  logic [9:0] expQ [$];

  localparam logic [9:0] EOF_GOOD = 10'h300;
  localparam logic [9:0] EOF_BAD  = 10'h200;

  uart_slip_deframer_if bus ();

  uart_slip_deframer #(.MAX_LEN(255), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .overflow (overflow),
    .in_frame (in_frame)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic err);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_error = err;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_error = 1'b0;
  endtask

  task automatic sendBytes(input logic [7:0] bytes [$]);
    foreach (bytes[i]) applyStimulus(bytes[i], 1'b0);
  endtask

  task automatic pushExp(input logic [9:0] entry);
    expQ.push_back(entry);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    checkOutput(tag, expQ.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) checkOutput("unexpectedEntry", expQ.size(), 1);
      else checkOutput("outEntry", {bus.out_eof, bus.out_good, bus.out_data}, expQ.pop_front());
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.in_error  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("resetOutputs",
                {bus.out_valid, bus.out_data, bus.out_eof, bus.out_good, overflow, in_frame}, 0);

    // Bytes before the first END are ignored in HUNT
    sendBytes('{8'h11, 8'h22, 8'h05});
    @(negedge clk);
    checkOutput("huntIgnore", {bus.out_valid, in_frame}, 0);

    pushExp(10'h001); pushExp(10'h002); pushExp(EOF_GOOD);
    sendBytes('{8'hC0, 8'h01, 8'h02, 8'hFD, 8'hC0});
    drain("drainGood");
    checkOutput("noOverflow", overflow, 0);

    pushExp(10'h0C0); pushExp(EOF_GOOD);
    sendBytes('{8'hC0, 8'hDB, 8'hDC, 8'h40, 8'hC0});
    pushExp(10'h0DB); pushExp(EOF_GOOD);
    sendBytes('{8'hC0, 8'hDB, 8'hDD, 8'h25, 8'hC0});
    drain("drainEscapes");

    pushExp(10'h001); pushExp(10'h002); pushExp(EOF_BAD);
    sendBytes('{8'hC0, 8'h01, 8'h02, 8'h00, 8'hC0});
    drain("drainBadSum");

    pushExp(EOF_BAD);
    sendBytes('{8'hC0, 8'h05, 8'hC0});
    drain("drainRunt");

    sendBytes('{8'hC0, 8'hC0, 8'hC0});
    @(negedge clk);
    checkOutput("emptyFrames", bus.out_valid, 0);

    pushExp(EOF_BAD);
    sendBytes('{8'hC0, 8'h11, 8'hDB, 8'h55, 8'h22, 8'hC0});
    drain("drainBadEsc");

    // UART error mid-frame, then discard until END
    pushExp(10'h001); pushExp(10'h002); pushExp(EOF_BAD);
    sendBytes('{8'hC0, 8'h01, 8'h02, 8'h03});
    applyStimulus(8'h00, 1'b1);
    @(negedge clk);
    checkOutput("errorLeavesFrame", in_frame, 0);
    sendBytes('{8'h04, 8'h05, 8'hC0});
    drain("drainError");

    // Error together with a byte wins; the byte is not decoded
    pushExp(10'h001); pushExp(EOF_BAD);
    sendBytes('{8'hC0, 8'h01, 8'h02});
    applyStimulus(8'h03, 1'b1);
    sendBytes('{8'hC0});
    drain("drainErrPriority");

    // Full FIFO with a stalled consumer
    bus.out_ready = 1'b0;
    sendBytes('{8'hC0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
    @(negedge clk);
    checkOutput("fullHead", {bus.out_valid, bus.out_eof, bus.out_good, bus.out_data}, 11'h401);
    checkOutput("overflowSet", overflow, 1);
    checkOutput("discardState", in_frame, 0);
    sendBytes('{8'h07, 8'hC0});
    pushExp(10'h001); pushExp(10'h002); pushExp(10'h003); pushExp(10'h004);
    bus.out_ready = 1'b1;
    drain("drainOverflow");
    checkOutput("overflowSticky", overflow, 1);

    // Reset mid-frame drops FIFO contents and returns to HUNT
    bus.out_ready = 1'b0;
    sendBytes('{8'hC0, 8'h01, 8'h02, 8'h03});
    @(negedge clk);
    checkOutput("midFrame", {bus.out_valid, in_frame}, 2'b11);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("afterReset", {bus.out_valid, in_frame, overflow}, 0);
    bus.out_ready = 1'b1;
    pushExp(10'h001); pushExp(EOF_GOOD);
    sendBytes('{8'h01, 8'hC0, 8'h01, 8'hFF, 8'hC0});
    drain("drainAfterReset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
